// File: rtl/shift_pipe.sv
// shift_pipe: DEPTH-stage enable/flush shift pipeline with per-stage valid, saturating tap mux and occupancy count.
module shift_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  input  logic             en,
  input  logic             flush,
  input  logic [SW-1:0]    sel,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic [OW-1:0]    occ
);
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [SW-1:0]    sel_s;
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    occ_d  = occ_q;
    if (flush) begin
      data_d = '{default: '0};
      vld_d  = '0;
      occ_d  = '0;
    end else if (en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      data_d[0] = d;
      vld_d[0]  = d_vld;
      // occupancy tracks popcount: one valid may enter and one may leave per shift
      occ_d = occ_q + OW'(d_vld) - OW'(vld_q[DEPTH-1]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '{default: '0};
      vld_q  <= '0;
      occ_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      occ_q  <= occ_d;
    end
  end
  assign sel_s = (DEPTH == 1 || 32'(sel) >= DEPTH) ? SW'(DEPTH - 1) : sel;
  assign q     = data_q[sel_s];
  assign q_vld = vld_q[sel_s];
  assign occ   = occ_q;
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: randomized and directed checks of shift_pipe (DEPTH 4, 5, 1) against a queue-based model.
module tb_shift_pipe;
  typedef struct packed {logic v; logic [7:0] d;} ent_t;
  typedef ent_t eq_t[$];
  logic clk, rst_n, d_vld, en, flush, chk_on;
  logic [7:0] d, q4, q5, q1;
  logic [1:0] sel4;
  logic [2:0] sel5, occ4, occ5;
  logic [0:0] sel1, occ1;
  logic qv4, qv5, qv1;
  int vectors = 0, miscompares = 0;
  eq_t m4, m5, m1;
  shift_pipe #(.WIDTH(8), .DEPTH(4)) u4 (.clk(clk), .rst_n(rst_n), .d(d), .d_vld(d_vld), .en(en),
    .flush(flush), .sel(sel4), .q(q4), .q_vld(qv4), .occ(occ4));
  shift_pipe #(.WIDTH(8), .DEPTH(5)) u5 (.clk(clk), .rst_n(rst_n), .d(d), .d_vld(d_vld), .en(en),
    .flush(flush), .sel(sel5), .q(q5), .q_vld(qv5), .occ(occ5));
  shift_pipe #(.WIDTH(8), .DEPTH(1)) u1 (.clk(clk), .rst_n(rst_n), .d(d), .d_vld(d_vld), .en(en),
    .flush(flush), .sel(sel1), .q(q1), .q_vld(qv1), .occ(occ1));
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic eq_t zq(input int dp);
    eq_t r;
    repeat (dp) r.push_back('0);
    return r;
  endfunction
  function automatic eq_t nxt(input eq_t qq, input int dp);
    if (flush) return zq(dp);
    if (en) begin
      qq.push_front({d_vld, d});
      void'(qq.pop_back());
    end
    return qq;
  endfunction
  function automatic ent_t tap(input eq_t qq, input int dp, input int s);
    return qq[(s < dp) ? s : dp - 1];
  endfunction
  function automatic int cnt(input eq_t qq);
    int n = 0;
    foreach (qq[i]) n += int'(qq[i].v);
    return n;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: each DUT is a queue of DEPTH entries, newest at the front
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 = zq(4); m5 = zq(5); m1 = zq(1);
    end else begin
      m4 = nxt(m4, 4); m5 = nxt(m5, 5); m1 = nxt(m1, 1);
    end
  end
  always @(negedge clk) begin
    ent_t e;
    if (chk_on) begin
      e = tap(m4, 4, int'(sel4));
      chk("q4", q4, e.d); chk("qv4", qv4, e.v); chk("occ4", occ4, cnt(m4));
      e = tap(m5, 5, int'(sel5));
      chk("q5", q5, e.d); chk("qv5", qv5, e.v); chk("occ5", occ5, cnt(m5));
      e = tap(m1, 1, int'(sel1));
      chk("q1", q1, e.d); chk("qv1", qv1, e.v); chk("occ1", occ1, cnt(m1));
    end
  end
  task automatic cyc(input logic v, input logic [7:0] x, input logic e_, input logic f);
    d_vld = v; d = x; en = e_; flush = f;
    @(posedge clk); #1;
  endtask
  initial begin
    logic [7:0] seq [5];
    logic [7:0] tapv [4];
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    tapv = '{8'h99, 8'h88, 8'h77, 8'h66};
    chk_on = 0; rst_n = 1; d = 0; d_vld = 0; en = 0; flush = 0;
    sel4 = 3; sel5 = 0; sel1 = 0;
    #2 rst_n = 0;
    #1 chk_on = 1;
    chk("rst_q4", q4, 0); chk("rst_qv4", qv4, 0); chk("rst_occ4", occ4, 0);
    d = 8'hFF; d_vld = 1; en = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    chk("rst_hold_occ4", occ4, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, seq[i], 1, 0);
      chk("fill_occ4", occ4, (i < 3) ? i + 1 : 4);
      chk("fill_qv4", qv4, i >= 3);
      chk("fill_q4", q4, (i >= 3) ? seq[i-3] : 8'h00);
    end
    repeat (3) begin
      cyc(1, 8'hEE, 0, 0);
      chk("stall_q4", q4, 8'h22); chk("stall_qv4", qv4, 1); chk("stall_occ4", occ4, 4);
    end
    cyc(1, 8'h66, 1, 0); chk("resume_q4", q4, 8'h33);
    cyc(1, 8'h77, 1, 0); chk("resume_q4", q4, 8'h44);
    cyc(1, 8'h88, 1, 0); chk("resume_q4", q4, 8'h55);
    cyc(1, 8'h99, 1, 0); chk("resume_q4", q4, 8'h66);
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s); #1;
      chk("sweep_q4", q4, tapv[s]); chk("sweep_occ4", occ4, 4);
    end
    sel5 = 7; #1 chk("sat_q5", q5, 8'h55);
    sel5 = 4; #1 chk("tap4_q5", q5, 8'h55);
    sel1 = 1; #1 chk("d1_q1", q1, 8'h99);
    cyc(1, 8'hAA, 1, 1);
    chk("flush_occ4", occ4, 0); chk("flush_occ5", occ5, 0);
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s); #1;
      chk("flush_q4", q4, 0); chk("flush_qv4", qv4, 0);
    end
    sel4 = 1;
    for (int i = 0; i < 8; i++) cyc(1'(i % 2 == 0), 8'(i + 1), 1, 0);
    chk("alt_occ4", occ4, 2); chk("alt_q4", q4, 8'h07); chk("alt_qv4", qv4, 1);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hC0 + i), 1, 0);
    #2 rst_n = 0;
    #1 chk("arst_q4", q4, 0); chk("arst_qv4", qv4, 0); chk("arst_occ4", occ4, 0);
    d_vld = 1; en = 1;
    @(posedge clk); #1 chk("arst_hold_occ4", occ4, 0);
    rst_n = 1;
    cyc(1, 8'h5A, 1, 0);
    chk("refill_occ4", occ4, 1); sel4 = 0; #1 chk("refill_q4", q4, 8'h5A);
    for (int i = 0; i < 600; i++) begin
      d = 8'($urandom); d_vld = 1'($urandom); en = ($urandom % 8) != 0;
      flush = ($urandom % 20) == 0;
      sel4 = 2'($urandom); sel5 = 3'($urandom); sel1 = 1'($urandom);
      if ($urandom % 50 == 0) begin
        #2 rst_n = 0;
        #1 rst_n = 1;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
